shift_deserializer: RTL and testbench
=====================================

Name: shift_deserializer

Overview:
- Serial-in/parallel-out receiver; the receive end of the serial link driven by the team's parallel-load shifter (its `shiftout` feeds our `shiftin`).
- Collects SHIFT_WIDTH bits framed by a start strobe into a shift register, then hands the completed word to a double-buffered output register.
- Output uses a valid/ready handshake, so reception of the next word continues while the consumer stalls.

Parameters:
- SHIFT_WIDTH, 8, data word width in bits (>=2).
- SHIFT_DIRECTION, 0, bit order. 0 = MSB first (pairs with the left-shifting transmitter); 1 = LSB first.
- CLR_VALUE, 0, value of q after sclr. Width SHIFT_WIDTH.

Ports:
- clock, input, 1, sole clock; all state updates on the rising edge.
- sclr, input, 1, synchronous active-high reset.
- shiftin, input, 1, serial data bit; sampled only when enable=1.
- enable, input, 1, bit strobe. One bit is consumed per clock with enable=1.
- frame, input, 1, qualified by enable. Marks the current bit as bit 0 of a new word.
- q, output, SHIFT_WIDTH, last completed word.
- q_valid, output, 1, q holds an unconsumed word.
- q_ready, input, 1, consumer accepts q on a cycle with q_valid=1.
- overrun, output, 1, sticky; a completed word was dropped.
- parity_err, output, 1, sticky parity failure; see Optional Feature.

Behaviour:
- Reset: sclr=1 at a rising edge forces the following, regardless of any other input. A partial word is discarded.
  - state=IDLE, bit counter=0, shift reg=0
  - q=CLR_VALUE, q_valid=0, overrun=0, parity_err=0
- FSM states: IDLE, RECV (plus PAR when DESER_PARITY_EN is defined).
- IDLE:
  - enable=1 & frame=1: store shiftin as bit 0, counter=1, go to RECV.
  - enable=1 & frame=0: bit ignored.
- RECV, on enable=1 & frame=0: store the bit and increment the counter.
- RECV, on enable=1 & frame=1: resync. Discard the partial word, store this bit as bit 0, counter=1. No flag is raised.
- RECV, enable=0: hold all state. Gaps between bits of any length are legal.
- Bit placement:
  - SHIFT_DIRECTION=0: shift left, new bit enters LSB. The first-received bit ends in q[SHIFT_WIDTH-1].
  - SHIFT_DIRECTION=1: shift right, new bit enters MSB. The first-received bit ends in q[0].
- Completion: the edge sampling bit index SHIFT_WIDTH-1 is the completion edge.
  - It loads q with the full word (including that bit) and sets q_valid=1 on that same edge.
  - State returns to IDLE.
  - Latency: q is visible one edge after the last bit is driven.
- Handshake:
  - q_valid=1 & q_ready=1 at an edge: the word is consumed and q_valid clears, unless a completion occurs on the same edge.
  - Completion with q_valid=0: q loaded, q_valid=1.
  - Completion with q_valid=1 & q_ready=1 on the same edge: new word loaded, q_valid stays 1. This is not an overrun.
  - Completion with q_valid=1 & q_ready=0: new word dropped, q unchanged, overrun set until sclr.
  - q is stable while q_valid=1 & q_ready=0.
- q_ready with q_valid=0: no effect.
- Back-to-back: frame may accompany the bit immediately after the completion edge. Zero idle cycles are required between words.

Optional Feature:
- Macro: DESER_PARITY_EN.
- Defined:
  - After bit SHIFT_WIDTH-1 the FSM enters PAR and the next enabled bit is an even-parity bit: XOR of data and parity must be 0.
  - The parity edge is the completion edge; latency grows by one bit time.
  - On mismatch the word is still delivered and parity_err is set until sclr.
  - frame=1 during PAR resyncs as in RECV; the pending word is discarded.
- Undefined: no PAR state; parity_err is tied 0.

Decomposition:
- Package shift_pkg contains:
  - the FSM state enum (IDLE, RECV, PAR);
  - localparam MSB_FIRST=0 and LSB_FIRST=1;
  - the counter-width function clog2(SHIFT_WIDTH+1).
- The same package is shared with the transmitter side.
- One natural sub-module: shift_out_buffer. It holds the q/q_valid/overrun register and its handshake; the FSM and shift register stay in the top level.

Test Plan:
- MSB-first word:
  - Stimulus: frame+enable on the first bit, serial 1,0,0,0,1,0,0,0, q_ready=1.
  - Response: q=8'h88 and q_valid=1 after the 8th edge, then cleared next edge; overrun=0.
- LSB-first word:
  - Stimulus: SHIFT_DIRECTION=1, same bits, enable toggled 1,0 each cycle.
  - Response: q=8'h11 after 16 cycles.
- Overrun:
  - Stimulus: two back-to-back words 8'hA5 then 8'h3C with q_ready=0.
  - Response: q stays 8'hA5, overrun=1.
  - Then q_ready=1: q_valid clears next edge; overrun stays 1.
- Simultaneous consume and completion:
  - Stimulus: q_ready=1 on the 2nd word's completion edge.
  - Response: q=8'h3C, q_valid stays 1, overrun=0.
- Resync and mid-word reset:
  - Stimulus A: 4 bits, then frame with 8 new bits 8'hFF. Response: q=8'hFF.
  - Stimulus B: sclr after 5 bits, then continued enabled bits without frame. Response: q=CLR_VALUE, q_valid=0, no word is produced.
- Parity (DESER_PARITY_EN):
  - Stimulus: 8'h88 followed by parity bit 0. Response: q=8'h88, parity_err=0.
  - Stimulus: 8'h88 followed by parity bit 1. Response: q=8'h88, parity_err=1 (sticky).

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the serial link: FSM states, bit-order codes and the
// counter-width helper used by both the transmitter and the receiver.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    PAR  = 2'd2
  } shift_state_t;

  localparam int MSB_FIRST = 0;
  localparam int LSB_FIRST = 1;

  // Ceiling log2; callers pass SHIFT_WIDTH+1 so the counter can also hold SHIFT_WIDTH.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_deserializer_if.sv
// Serial input strobes plus the valid/ready word output of shift_deserializer.
// master = producer of the serial stream / consumer of words; slave = the receiver.
interface shift_deserializer_if #(
  parameter int SHIFT_WIDTH = 8
);
  logic                   shiftin;
  logic                   enable;
  logic                   frame;
  logic                   q_ready;
  logic [SHIFT_WIDTH-1:0] q;
  logic                   q_valid;
  logic                   overrun;
  logic                   parity_err;

  modport master (
    output shiftin, enable, frame, q_ready,
    input  q, q_valid, overrun, parity_err
  );

  modport slave (
    input  shiftin, enable, frame, q_ready,
    output q, q_valid, overrun, parity_err
  );
endinterface

// File: rtl/shift_out_buffer.sv
// Output word register with valid/ready handshake and sticky overrun flag.
// A new word is dropped only when the current one is still held and not being consumed.
module shift_out_buffer #(
  parameter int                     SHIFT_WIDTH = 8,
  parameter logic [SHIFT_WIDTH-1:0] CLR_VALUE   = '0
) (
  input  logic                   clock,
  input  logic                   sclr,
  input  logic                   load,
  input  logic [SHIFT_WIDTH-1:0] word,
  input  logic                   q_ready,
  output logic [SHIFT_WIDTH-1:0] q,
  output logic                   q_valid,
  output logic                   overrun
);

  logic [SHIFT_WIDTH-1:0] q_reg;
  logic                   q_valid_reg;
  logic                   overrun_reg;

  always_ff @(posedge clock) begin
    if (sclr) begin
      q_reg       <= CLR_VALUE;
      q_valid_reg <= 1'b0;
      overrun_reg <= 1'b0;
    end else if (load) begin
      if (q_valid_reg && !q_ready) begin
        overrun_reg <= 1'b1;
      end else begin
        q_reg       <= word;
        q_valid_reg <= 1'b1;
      end
    end else if (q_valid_reg && q_ready) begin
      q_valid_reg <= 1'b0;
    end
  end

  assign q       = q_reg;
  assign q_valid = q_valid_reg;
  assign overrun = overrun_reg;

endmodule

// File: rtl/shift_deserializer.sv
// Framed serial-in/parallel-out receiver feeding a double-buffered valid/ready output.
// Optional even-parity bit after each word when DESER_PARITY_EN is defined.
module shift_deserializer
  import shift_pkg::*;
#(
  parameter int                     SHIFT_WIDTH     = 8,
  parameter int                     SHIFT_DIRECTION = MSB_FIRST,
  parameter logic [SHIFT_WIDTH-1:0] CLR_VALUE       = '0
) (
  input logic                  clock,
  input logic                  sclr,
  shift_deserializer_if.slave  bus
);

  localparam int               CNT_W    = clog2(SHIFT_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SHIFT_WIDTH - 1);

  shift_state_t           state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [SHIFT_WIDTH-1:0] shreg_reg, shreg_next;
  logic [SHIFT_WIDTH-1:0] shift_base;
  logic [SHIFT_WIDTH-1:0] shifted;
  logic [SHIFT_WIDTH-1:0] word;
  logic                   complete;
  logic [SHIFT_WIDTH-1:0] buf_q;
  logic                   buf_q_valid;
  logic                   buf_overrun;
`ifdef DESER_PARITY_EN
  logic                   par_bad;
  logic                   parity_err_reg;
`endif

  // A framed bit starts from an empty register so a resync leaves no stale bits.
  assign shift_base = bus.frame ? '0 : shreg_reg;

  genvar gi;
  generate
    for (gi = 0; gi < SHIFT_WIDTH; gi++) begin : g_shift
      if (SHIFT_DIRECTION == MSB_FIRST) begin : g_left
        if (gi == 0) begin : g_in
          assign shifted[gi] = bus.shiftin;
        end else begin : g_mv
          assign shifted[gi] = shift_base[gi-1];
        end
      end else begin : g_right
        if (gi == SHIFT_WIDTH - 1) begin : g_in
          assign shifted[gi] = bus.shiftin;
        end else begin : g_mv
          assign shifted[gi] = shift_base[gi+1];
        end
      end
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    shreg_next = shreg_reg;
    word       = shifted;
    complete   = 1'b0;
`ifdef DESER_PARITY_EN
    par_bad    = 1'b0;
`endif
    if (bus.enable) begin
      if (bus.frame) begin
        state_next = RECV;
        cnt_next   = CNT_W'(1);
        shreg_next = shifted;
      end else begin
        case (state_reg)
          RECV: begin
            shreg_next = shifted;
            cnt_next   = cnt_reg + CNT_W'(1);
            if (cnt_reg == LAST_IDX) begin
`ifdef DESER_PARITY_EN
              state_next = PAR;
`else
              state_next = IDLE;
              cnt_next   = '0;
              complete   = 1'b1;
`endif
            end
          end
`ifdef DESER_PARITY_EN
          // The parity bit is the completion edge; the word itself is already in shreg.
          PAR: begin
            word       = shreg_reg;
            complete   = 1'b1;
            par_bad    = (^shreg_reg) ^ bus.shiftin;
            state_next = IDLE;
            cnt_next   = '0;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      shreg_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      shreg_reg <= shreg_next;
    end
  end

`ifdef DESER_PARITY_EN
  always_ff @(posedge clock) begin
    if (sclr) begin
      parity_err_reg <= 1'b0;
    end else if (complete && par_bad) begin
      parity_err_reg <= 1'b1;
    end
  end
  assign bus.parity_err = parity_err_reg;
`else
  assign bus.parity_err = 1'b0;
`endif

  shift_out_buffer #(
    .SHIFT_WIDTH (SHIFT_WIDTH),
    .CLR_VALUE   (CLR_VALUE)
  ) u_out_buffer (
    .clock   (clock),
    .sclr    (sclr),
    .load    (complete),
    .word    (word),
    .q_ready (bus.q_ready),
    .q       (buf_q),
    .q_valid (buf_q_valid),
    .overrun (buf_overrun)
  );

  assign bus.q       = buf_q;
  assign bus.q_valid = buf_q_valid;
  assign bus.overrun = buf_overrun;

endmodule

// File: tb/tb_shift_deserializer.sv
// Bench for shift_deserializer: MSB-first and LSB-first instances share one serial
// stream and are compared every cycle against a bit-queue reference model.
module tb_shift_deserializer;
  import shift_pkg::*;

  localparam int W = 8;
  localparam logic [W-1:0] CLR0 = 8'h5A;
  localparam logic [W-1:0] CLR1 = 8'hC3;
`ifdef DESER_PARITY_EN
  localparam int NBITS = W + 1;
`else
  localparam int NBITS = W;
`endif

  logic clock = 1'b0;
  logic sclr, shiftin, enable, frame, q_ready;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  shift_deserializer_if #(.SHIFT_WIDTH(W)) bus0 ();
  shift_deserializer_if #(.SHIFT_WIDTH(W)) bus1 ();

  assign bus0.shiftin = shiftin;
  assign bus0.enable  = enable;
  assign bus0.frame   = frame;
  assign bus0.q_ready = q_ready;
  assign bus1.shiftin = shiftin;
  assign bus1.enable  = enable;
  assign bus1.frame   = frame;
  assign bus1.q_ready = q_ready;

  shift_deserializer #(
    .SHIFT_WIDTH(W), .SHIFT_DIRECTION(MSB_FIRST), .CLR_VALUE(CLR0)
  ) dut0 (.clock(clock), .sclr(sclr), .bus(bus0));

  shift_deserializer #(
    .SHIFT_WIDTH(W), .SHIFT_DIRECTION(LSB_FIRST), .CLR_VALUE(CLR1)
  ) dut1 (.clock(clock), .sclr(sclr), .bus(bus1));

  // Reference model: bits of the current frame in arrival order.
  logic         m_known = 1'b0;
  logic         m_active;
  logic         m_bits[$];
  logic [W-1:0] m_q0, m_q1;
  logic         m_valid, m_ovr, m_perr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [W-1:0] w0, w1;
    logic         p;
    if (sclr) begin
      m_known  = 1'b1;
      m_active = 1'b0;
      m_bits.delete();
      m_q0 = CLR0; m_q1 = CLR1;
      m_valid = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
    end else begin
      if (enable) begin
        if (frame) begin
          m_bits.delete();
          m_bits.push_back(shiftin);
          m_active = 1'b1;
        end else if (m_active) begin
          m_bits.push_back(shiftin);
        end
      end
      if (m_active && m_bits.size() == NBITS) begin
        w0 = '0; w1 = '0; p = 1'b0;
        for (int i = 0; i < W; i++) begin
          w0[W-1-i] = m_bits[i];
          w1[i]     = m_bits[i];
        end
        for (int i = 0; i < NBITS; i++) p = p ^ m_bits[i];
        m_active = 1'b0;
        m_bits.delete();
        if (m_valid && !q_ready) begin
          m_ovr = 1'b1;
        end else begin
          m_q0 = w0; m_q1 = w1; m_valid = 1'b1;
        end
        if (NBITS > W && p) m_perr = 1'b1;
      end else if (m_valid && q_ready) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    if (m_known) begin
      check("q_msb",       bus0.q,          m_q0);
      check("q_lsb",       bus1.q,          m_q1);
      check("valid_msb",   bus0.q_valid,    m_valid);
      check("valid_lsb",   bus1.q_valid,    m_valid);
      check("overrun_msb", bus0.overrun,    m_ovr);
      check("overrun_lsb", bus1.overrun,    m_ovr);
      check("perr_msb",    bus0.parity_err, m_perr);
      check("perr_lsb",    bus1.parity_err, m_perr);
    end
  endtask

  task automatic drive(input logic en, input logic fr, input logic b);
    enable = en; frame = fr; shiftin = b;
    tick();
  endtask

  // Sends w MSB first (plus parity bit when enabled); optional idle gap after every bit.
  task automatic send_word(input logic [W-1:0] w, input bit gaps, input bit rdy_last,
                           input bit bad_par);
    logic b;
    for (int i = 0; i < NBITS; i++) begin
      b = (i < W) ? w[W-1-i] : ((^w) ^ bad_par);
      if (i == NBITS - 1 && rdy_last) q_ready = 1'b1;
      drive(1'b1, (i == 0), b);
      if (gaps) drive(1'b0, 1'b0, 1'($urandom));
    end
  endtask

  task automatic do_reset();
    sclr = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    sclr = 1'b0;
  endtask

  initial begin
    sclr = 1'b1; shiftin = 1'b0; enable = 1'b0; frame = 1'b0; q_ready = 1'b0;
    do_reset();
    check("reset_q_msb", bus0.q, CLR0);
    check("reset_q_lsb", bus1.q, CLR1);
    check("reset_valid", bus0.q_valid, 1'b0);

    // MSB-first 1,0,0,0,1,0,0,0 with continuous ready
    q_ready = 1'b1;
    send_word(8'h88, 1'b0, 1'b0, 1'b0);
    check("msb_word", bus0.q, 8'h88);
    check("msb_word_lsbinst", bus1.q, 8'h11);
    check("msb_valid", bus0.q_valid, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    check("msb_consumed", bus0.q_valid, 1'b0);
    check("msb_no_overrun", bus0.overrun, 1'b0);

    // Same bits with enable toggled 1,0
    q_ready = 1'b0;
    send_word(8'h88, 1'b1, 1'b0, 1'b0);
    check("lsb_word", bus1.q, 8'h11);
    check("lsb_valid", bus1.q_valid, 1'b1);
    q_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    check("lsb_consumed", bus1.q_valid, 1'b0);

    // Overrun: back-to-back words while stalled
    q_ready = 1'b0;
    send_word(8'hA5, 1'b0, 1'b0, 1'b0);
    send_word(8'h3C, 1'b0, 1'b0, 1'b0);
    check("ovr_q_held", bus0.q, 8'hA5);
    check("ovr_flag", bus0.overrun, 1'b1);
    q_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    check("ovr_consumed", bus0.q_valid, 1'b0);
    check("ovr_sticky", bus0.overrun, 1'b1);

    // Consume on the same edge the next word completes
    do_reset();
    q_ready = 1'b0;
    send_word(8'hA5, 1'b0, 1'b0, 1'b0);
    send_word(8'h3C, 1'b0, 1'b1, 1'b0);
    check("simul_q", bus0.q, 8'h3C);
    check("simul_valid", bus0.q_valid, 1'b1);
    check("simul_no_ovr", bus0.overrun, 1'b0);
    drive(1'b0, 1'b0, 1'b0);

    // Resync: 4 bits then a fresh framed word
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    send_word(8'hFF, 1'b0, 1'b0, 1'b0);
    check("resync_q", bus0.q, 8'hFF);
    drive(1'b0, 1'b0, 1'b0);

    // Mid-word reset: unframed bits afterwards produce nothing
    for (int i = 0; i < 5; i++) drive(1'b1, (i == 0), 1'b1);
    do_reset();
    for (int i = 0; i < NBITS + 2; i++) drive(1'b1, 1'b0, 1'b1);
    check("midreset_q", bus0.q, CLR0);
    check("midreset_valid", bus0.q_valid, 1'b0);

`ifdef DESER_PARITY_EN
    send_word(8'h88, 1'b0, 1'b0, 1'b0);
    check("par_good_q", bus0.q, 8'h88);
    check("par_good_err", bus0.parity_err, 1'b0);
    send_word(8'h88, 1'b0, 1'b0, 1'b1);
    check("par_bad_q", bus0.q, 8'h88);
    check("par_bad_err", bus0.parity_err, 1'b1);
    send_word(8'h11, 1'b0, 1'b0, 1'b0);
    check("par_sticky", bus0.parity_err, 1'b1);
`endif

    // Randomized traffic, checked every cycle by the model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      q_ready = ($urandom_range(0, 3) != 0);
      sclr    = ($urandom_range(0, 249) == 0);
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0), 1'($urandom));
    end
    sclr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
